sqrt_floor_iter: RTL

Parametrised, iterative integer square-root unit. It computes floor(sqrt(num)) and the remainder num − root² for an unsigned WIDTH-bit operand. It resolves one root bit per clock using the restoring digit-by-digit method, with a start/done handshake and a perfect-square flag. It is the generalised successor of the team's fixed 10-bit linear-search floor-sqrt: latency is fixed and independent of the operand, where the linear search took up to 32 cycles.

---
 rtl/sqrt_floor_iter_if.sv | 25 ++
 rtl/sqrt_floor_iter.sv | 92 +++++++++
 2 files changed

// File: rtl/sqrt_floor_iter_if.sv
// Start/done handshake bundle for the iterative floor-sqrt unit.
// The requester drives start/num; the unit returns status and the registered result.
interface sqrt_floor_iter_if #(
  parameter int unsigned WIDTH = 10
);
  localparam int unsigned ROOT_W = WIDTH / 2;

  logic              start;
  logic [WIDTH-1:0]  num;
  logic              busy;
  logic              done;
  logic [ROOT_W-1:0] sqrt;
  logic [ROOT_W:0]   rem;
  logic              exact;

  modport master (
    output start, num,
    input  busy, done, sqrt, rem, exact
  );

  modport slave (
    input  start, num,
    output busy, done, sqrt, rem, exact
  );
endinterface

// File: rtl/sqrt_floor_iter.sv
// Iterative integer square root: one root bit per clock (restoring digit-by-digit),
// producing floor(sqrt(num)), the remainder and a perfect-square flag.
module sqrt_floor_iter #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  sqrt_floor_iter_if.slave bus
);
  localparam int unsigned ROOT_W = WIDTH / 2;
  localparam int unsigned REM_W  = ROOT_W + 2;
  localparam int unsigned CNT_W  = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("sqrt_floor_iter: WIDTH must be even and at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  opnd;
  logic [ROOT_W-1:0] q;
  logic [REM_W-1:0]  r;
  logic [CNT_W-1:0]  cnt;

  logic [REM_W-1:0]  r_sh;
  logic [REM_W-1:0]  trial;
  logic [REM_W-1:0]  r_new;
  logic [ROOT_W-1:0] q_new;
  logic              fits;

  // One restoring step: bring down two operand bits and try subtracting (4q+1).
  always_comb begin
    r_sh  = {r[REM_W-3:0], opnd[WIDTH-1 -: 2]};
    trial = {q, 2'b01};
    fits  = (r_sh >= trial);
    r_new = fits ? (r_sh - trial) : r_sh;
    q_new = ROOT_W'({q, fits});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      opnd      <= '0;
      q         <= '0;
      r         <= '0;
      cnt       <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.sqrt  <= '0;
      bus.rem   <= '0;
      bus.exact <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state    <= CALC;
            opnd     <= bus.num;
            q        <= '0;
            r        <= '0;
            cnt      <= CNT_W'(ROOT_W - 1);
            bus.busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          opnd <= opnd << 2;
          q    <= q_new;
          r    <= r_new;
          // Last root bit resolved: publish the result; rem <= 2*sqrt fits ROOT_W+1 bits.
          if (cnt == '0) begin
            state     <= DONE;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            bus.sqrt  <= q_new;
            bus.rem   <= r_new[ROOT_W:0];
            bus.exact <= (r_new == '0);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
